// File: rtl/scudsp_xfer_pkg.sv
// Shared types for the SCU DSP transfer engine: FSM states, latched command
// record and the transfer-count width extension.
package scudsp_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } XferState_t;

  // Bank field is sized for the largest supported configuration (8 banks).
  localparam int unsigned BANK_W_MAX = 3;

  // One extra TN bit so that a zero start count can hold 2^CNT_W.
  localparam int unsigned TN_EXT = 1;

  typedef struct packed {
    logic                  dir;
    logic [BANK_W_MAX-1:0] bank;
    logic                  hold;
  } XferCmd_t;

endpackage

// File: rtl/scu_dsp_xfer_engine_if.sv
// Bus-side handshake between the transfer engine (master) and the SCU bus
// arbiter (slave).
interface scu_dsp_xfer_engine_if #(
  parameter int unsigned DW = 32
);
  logic          BUS_REQ;
  logic          BUS_ACK;
  logic          BUS_LAST;
  logic          BUS_END;
  logic          BUS_WE;
  logic [DW-1:0] BUS_DI;
  logic [DW-1:0] BUS_DO;

  modport master (
    output BUS_REQ, BUS_LAST, BUS_WE, BUS_DO,
    input  BUS_ACK, BUS_END, BUS_DI
  );

  modport slave (
    input  BUS_REQ, BUS_LAST, BUS_WE, BUS_DO,
    output BUS_ACK, BUS_END, BUS_DI
  );
endinterface

// File: rtl/scu_dsp_xfer_ctr.sv
// One bank address counter (CTn): soft clear, then load, then increment;
// wraps modulo 2^ADDR_W.
module scu_dsp_xfer_ctr #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ct
);

  logic [ADDR_W-1:0] ct_q, ct_d;

  // Beat and instruction increments arrive pre-ORed on inc, so a collision
  // advances by one only.
  always_comb begin
    ct_d = ct_q;
    if (clr) begin
      ct_d = '0;
    end else if (load) begin
      ct_d = load_val;
    end else if (inc) begin
      ct_d = ct_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ct_q <= '0;
    end else begin
      ct_q <= ct_d;
    end
  end

  assign ct = ct_q;

endmodule

// File: rtl/scu_dsp_xfer_engine.sv
// DMA transfer sequencer between the D0 bus and BANKS data RAMs.
// Optional statistics outputs are built when SCU_DSP_XFER_STAT_EN is defined.
module scu_dsp_xfer_engine
  import scudsp_xfer_pkg::*;
#(
  parameter int unsigned BANKS  = 4,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DW     = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       RES_N,
  input  logic                       CE_R,
  input  logic                       CE_F,
  input  logic                       CE,
  input  logic                       START,
  input  logic                       START_DIR,
  input  logic [$clog2(BANKS)-1:0]   START_BANK,
  input  logic [CNT_W-1:0]           START_CNT,
  input  logic                       START_HOLD,
  input  logic [BANKS-1:0]           CT_LOAD,
  input  logic [ADDR_W-1:0]          CT_LOAD_VAL,
  input  logic [BANKS-1:0]           CT_INC,
  output logic [BANKS*ADDR_W-1:0]    CT_OUT,
  output logic                       BUSY,
  output logic                       DONE,
  scu_dsp_xfer_engine_if.master      bus,
  output logic [DW-1:0]              RAM_D,
  output logic [BANKS-1:0]           RAM_WE,
  input  logic [BANKS*DW-1:0]        RAM_Q
`ifdef SCU_DSP_XFER_STAT_EN
  ,
  output logic [31:0]                STAT_WORDS,
  output logic                       STAT_ABORT
`endif
);

  localparam int unsigned TN_W = CNT_W + TN_EXT;
  localparam logic [TN_W-1:0] TN_MAX = TN_W'(1) << CNT_W;

  XferState_t      state_q, state_d;
  XferCmd_t        cmd_q, cmd_d;
  logic [TN_W-1:0] tn_q, tn_d;
  logic            end_prev_q, end_prev_d;
  logic            end_pend_q, end_pend_d;
  logic            done_q, done_d;

  logic             beat;
  logic             end_fall;
  logic             finish;
  logic [BANKS-1:0] bank_sel;
  logic [DW-1:0]    bus_do;

  assign beat     = (state_q == XFER) && CE_R && bus.BUS_ACK;
  assign end_fall = CE_F && end_prev_q && !bus.BUS_END;
  assign finish   = CE && end_pend_q && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tn_d       = tn_q;
    end_prev_d = end_prev_q;
    end_pend_d = end_pend_q;
    done_d     = 1'b0;

    // A new falling edge wins over the per-CE clear of the pending flag.
    if (CE)       end_pend_d = 1'b0;
    if (CE_F)     end_prev_d = bus.BUS_END;
    if (end_fall) end_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (CE && START) begin
          cmd_d.dir  = START_DIR;
          cmd_d.bank = BANK_W_MAX'(START_BANK);
          cmd_d.hold = START_HOLD;
          tn_d       = (START_CNT == '0) ? TN_MAX : TN_W'(START_CNT);
          state_d    = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          tn_d = tn_q - TN_W'(1);
          if (tn_q <= TN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion or arbiter abort; TN is cleared so BUS_LAST cannot linger.
    if (finish) begin
      state_d = IDLE;
      tn_d    = '0;
      done_d  = 1'b1;
    end

    if (!RES_N) begin
      state_d    = IDLE;
      cmd_d      = '0;
      tn_d       = '0;
      end_prev_d = 1'b0;
      end_pend_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      tn_q       <= '0;
      end_prev_q <= 1'b0;
      end_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tn_q       <= tn_d;
      end_prev_q <= end_prev_d;
      end_pend_q <= end_pend_d;
      done_q     <= done_d;
    end
  end

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    assign bank_sel[gi] = (cmd_q.bank == BANK_W_MAX'(gi));
    assign RAM_WE[gi]   = beat && bank_sel[gi] && !cmd_q.dir;

    scu_dsp_xfer_ctr #(
      .ADDR_W (ADDR_W)
    ) u_ctr (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .clr      (!RES_N),
      .load     (CE && CT_LOAD[gi]),
      .load_val (CT_LOAD_VAL),
      .inc      ((beat && bank_sel[gi] && !cmd_q.hold) || (CE && CT_INC[gi])),
      .ct       (CT_OUT[gi*ADDR_W +: ADDR_W])
    );
  end

  always_comb begin
    bus_do = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      if (bank_sel[b]) bus_do = RAM_Q[b*DW +: DW];
    end
  end

  assign BUSY         = (state_q != IDLE);
  assign DONE         = done_q;
  assign bus.BUS_REQ  = (state_q == XFER);
  assign bus.BUS_LAST = (tn_q == TN_W'(1));
  assign bus.BUS_WE   = cmd_q.dir;
  assign bus.BUS_DO   = bus_do;
  assign RAM_D        = bus.BUS_DI;

`ifdef SCU_DSP_XFER_STAT_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic        stat_abort_q, stat_abort_d;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_abort_d = stat_abort_q;
    if (beat && (stat_words_q != '1)) stat_words_d = stat_words_q + 32'd1;
    if (end_fall && (tn_q != '0))     stat_abort_d = 1'b1;
    if (!RES_N) begin
      stat_words_d = '0;
      stat_abort_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_words_q <= '0;
      stat_abort_q <= 1'b0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_abort_q <= stat_abort_d;
    end
  end

  assign STAT_WORDS = stat_words_q;
  assign STAT_ABORT = stat_abort_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_scu_dsp_xfer_engine.sv
// Directed bench for scu_dsp_xfer_engine: a vector table for the basic write
// transfer, then hand sequences for wrap, hold, priority, soft reset and abort.
module tb_scu_dsp_xfer_engine;

  localparam int BANKS  = 4;
  localparam int ADDR_W = 6;
  localparam int DW     = 32;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    res_n = 1'b1;
  logic                    ce_r = 1'b1;
  logic                    ce_f = 1'b1;
  logic                    ce = 1'b1;
  logic                    start = 1'b0;
  logic                    start_dir = 1'b0;
  logic [1:0]              start_bank = '0;
  logic [CNT_W-1:0]        start_cnt = '0;
  logic                    start_hold = 1'b0;
  logic [BANKS-1:0]        ct_load = '0;
  logic [ADDR_W-1:0]       ct_load_val = '0;
  logic [BANKS-1:0]        ct_inc = '0;
  logic [BANKS*ADDR_W-1:0] ct_out;
  logic                    busy;
  logic                    done;
  logic [DW-1:0]           ram_d;
  logic [BANKS-1:0]        ram_we;
  logic [BANKS*DW-1:0]     ram_q;
`ifdef SCU_DSP_XFER_STAT_EN
  logic [31:0]             stat_words;
  logic                    stat_abort;
`endif

  scu_dsp_xfer_engine_if #(.DW(DW)) bus ();

  scu_dsp_xfer_engine #(
    .BANKS(BANKS), .ADDR_W(ADDR_W), .DW(DW), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .RES_N(res_n),
    .CE_R(ce_r), .CE_F(ce_f), .CE(ce),
    .START(start), .START_DIR(start_dir), .START_BANK(start_bank),
    .START_CNT(start_cnt), .START_HOLD(start_hold),
    .CT_LOAD(ct_load), .CT_LOAD_VAL(ct_load_val), .CT_INC(ct_inc),
    .CT_OUT(ct_out), .BUSY(busy), .DONE(done),
    .bus(bus),
    .RAM_D(ram_d), .RAM_WE(ram_we), .RAM_Q(ram_q)
`ifdef SCU_DSP_XFER_STAT_EN
    , .STAT_WORDS(stat_words), .STAT_ABORT(stat_abort)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: each bank returns a word tagged with its bank number and the
  // address currently on its counter.
  always_comb begin
    ram_q = '0;
    for (int b = 0; b < BANKS; b++)
      ram_q[b*DW +: DW] = {16'hA000, 8'(b), 2'b00, ct_out[b*ADDR_W +: ADDR_W]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ct_of(input int b);
    return ct_out[b*ADDR_W +: ADDR_W];
  endfunction

  // Raise then drop BUS_END and count DONE pulses over the following cycles.
  task automatic end_pulse(output int dones);
    bus.BUS_END = 1'b1;
    @(negedge clk);
    bus.BUS_END = 1'b0;
    dones = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (done) dones++;
    end
  endtask

  typedef struct {
    logic             start;
    logic [1:0]       bank;
    logic [CNT_W-1:0] cnt;
    logic             ack;
    logic             bend;
    logic [DW-1:0]    di;
    logic             exp_busy;
    logic             exp_req;
    logic             exp_last;
    logic             exp_done;
    logic [BANKS-1:0] exp_we;
    logic [ADDR_W-1:0] exp_ct2;
  } vec_t;

  vec_t vt[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    int beats;

    //          start bank cnt  ack end  di     busy req last done we       ct2
    vt[0] = '{1'b1, 2'd2, 8'd3, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd0};
    vt[1] = '{1'b0, 2'd2, 8'd3, 1'b1, 1'b0, 32'd11, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 6'd0};
    vt[2] = '{1'b1, 2'd1, 8'd7, 1'b1, 1'b0, 32'd22, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 6'd1};
    vt[3] = '{1'b0, 2'd2, 8'd3, 1'b1, 1'b0, 32'd33, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 6'd2};
    vt[4] = '{1'b0, 2'd2, 8'd3, 1'b1, 1'b1, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3};
    vt[5] = '{1'b0, 2'd2, 8'd3, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3};
    vt[6] = '{1'b0, 2'd2, 8'd3, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3};
    vt[7] = '{1'b0, 2'd2, 8'd3, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 6'd3};
    vt[8] = '{1'b0, 2'd2, 8'd3, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3};

    bus.BUS_ACK = 1'b0;
    bus.BUS_END = 1'b0;
    bus.BUS_DI  = '0;

    // Power-on reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_req", bus.BUS_REQ, 0);
    chk("reset_done", done, 0);
    chk("reset_we", bus.BUS_WE, 0);
    chk("reset_ram_we", ram_we, 0);
    chk("reset_ct", ct_out, 0);
    chk("reset_last", bus.BUS_LAST, 0);

    // Bank 2 write of three words; second START mid-transfer must be ignored
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start       = vt[i].start;
      start_bank  = vt[i].bank;
      start_cnt   = vt[i].cnt;
      bus.BUS_ACK = vt[i].ack;
      bus.BUS_END = vt[i].bend;
      bus.BUS_DI  = vt[i].di;
      #1;
      $display("vec %0d: busy=%0b req=%0b last=%0b done=%0b we=%b ct2=%0d",
               i, busy, bus.BUS_REQ, bus.BUS_LAST, done, ram_we, ct_of(2));
      chk($sformatf("v%0d_busy", i), busy, vt[i].exp_busy);
      chk($sformatf("v%0d_req", i), bus.BUS_REQ, vt[i].exp_req);
      chk($sformatf("v%0d_last", i), bus.BUS_LAST, vt[i].exp_last);
      chk($sformatf("v%0d_done", i), done, vt[i].exp_done);
      chk($sformatf("v%0d_ram_we", i), ram_we, vt[i].exp_we);
      chk($sformatf("v%0d_ct2", i), ct_of(2), vt[i].exp_ct2);
      chk($sformatf("v%0d_ram_d", i), ram_d, vt[i].di);
    end
    start = 1'b0;

    // Zero count means 256 beats; CT3 wraps 63 -> 0
    @(negedge clk);
    start = 1'b1; start_bank = 2'd3; start_cnt = 8'd0; start_dir = 1'b0;
    @(negedge clk);
    start = 1'b0; bus.BUS_ACK = 1'b1; beats = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!bus.BUS_REQ) break;
      if (beats == 63)  chk("wrap_ct3_63", ct_of(3), 63);
      if (beats == 64)  chk("wrap_ct3_0", ct_of(3), 0);
      if (beats == 255) chk("cnt0_last", bus.BUS_LAST, 1);
      if (ram_we[3]) beats++;
      @(negedge clk);
    end
    bus.BUS_ACK = 1'b0;
    $display("cnt0 transfer: beats=%0d ct3=%0d", beats, ct_of(3));
    chk("cnt0_beats", beats, 256);
    chk("cnt0_ct3_final", ct_of(3), 0);
    end_pulse(dones);
    chk("cnt0_done", dones, 1);

    // Hold mode read of bank 1 at address 5
    @(negedge clk);
    ct_load = 4'b0010; ct_load_val = 6'd5;
    @(negedge clk);
    ct_load = '0;
    start = 1'b1; start_bank = 2'd1; start_cnt = 8'd4; start_dir = 1'b1; start_hold = 1'b1;
    #1;
    chk("hold_ct1_loaded", ct_of(1), 5);
    @(negedge clk);
    start = 1'b0; bus.BUS_ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("hold beat %0d: bus_do=%0h ram_we=%b ct1=%0d", i, bus.BUS_DO, ram_we, ct_of(1));
      chk($sformatf("hold_do_%0d", i), bus.BUS_DO, 32'hA000_0105);
      chk($sformatf("hold_ram_we_%0d", i), ram_we, 0);
      chk($sformatf("hold_bus_we_%0d", i), bus.BUS_WE, 1);
      @(negedge clk);
    end
    bus.BUS_ACK = 1'b0;
    #1;
    chk("hold_ct1_final", ct_of(1), 5);
    chk("hold_req_drop", bus.BUS_REQ, 0);
    end_pulse(dones);
    chk("hold_done", dones, 1);
    start_dir = 1'b0; start_hold = 1'b0;

    // Counter priority: load beats a beat, beat plus CT_INC is +1
    @(negedge clk);
    start = 1'b1; start_bank = 2'd0; start_cnt = 8'd3;
    @(negedge clk);
    start = 1'b0; bus.BUS_ACK = 1'b1; ct_load = 4'b0001; ct_load_val = 6'd9;
    @(negedge clk); #1;
    chk("prio_load_ct0", ct_of(0), 9);
    ct_load = '0; ct_inc = 4'b0101;
    @(negedge clk); #1;
    chk("prio_inc_ct0", ct_of(0), 10);
    chk("prio_inc_ct2", ct_of(2), 4);
    ct_inc = '0;
    @(negedge clk); #1;
    chk("prio_last_ct0", ct_of(0), 11);
    chk("prio_req_drop", bus.BUS_REQ, 0);
    bus.BUS_ACK = 1'b0;
    end_pulse(dones);
    chk("prio_done", dones, 1);

    // Soft reset after 2 of 5 beats aborts without DONE
    @(negedge clk);
    start = 1'b1; start_bank = 2'd1; start_cnt = 8'd5;
    @(negedge clk);
    start = 1'b0; bus.BUS_ACK = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("sres_ct1_mid", ct_of(1), 7);
    bus.BUS_ACK = 1'b0; res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1; #1;
    chk("sres_busy", busy, 0);
    chk("sres_req", bus.BUS_REQ, 0);
    chk("sres_ct", ct_out, 0);
    chk("sres_last", bus.BUS_LAST, 0);
    end_pulse(dones);
    chk("sres_no_done", dones, 0);

    @(negedge clk);
    start = 1'b1; start_bank = 2'd1; start_cnt = 8'd2;
    @(negedge clk);
    start = 1'b0; bus.BUS_ACK = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("restart_ct1", ct_of(1), 2);
    chk("restart_req", bus.BUS_REQ, 0);
    bus.BUS_ACK = 1'b0;
    end_pulse(dones);
    chk("restart_done", dones, 1);
    chk("restart_busy", busy, 0);

    // Arbiter abort with TN=2 still outstanding
`ifdef SCU_DSP_XFER_STAT_EN
    chk("stat_abort_clear", stat_abort, 0);
    chk("stat_words_pre", stat_words, 2);
`endif
    @(negedge clk);
    start = 1'b1; start_bank = 2'd0; start_cnt = 8'd4;
    @(negedge clk);
    start = 1'b0; bus.BUS_ACK = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    bus.BUS_ACK = 1'b0;
    chk("abort_req_before", bus.BUS_REQ, 1);
    chk("abort_ct0", ct_of(0), 2);
    end_pulse(dones);
    chk("abort_done", dones, 1);
    chk("abort_busy", busy, 0);
    chk("abort_req_after", bus.BUS_REQ, 0);
`ifdef SCU_DSP_XFER_STAT_EN
    $display("stat: words=%0d abort=%0b", stat_words, stat_abort);
    chk("stat_abort_set", stat_abort, 1);
    chk("stat_words", stat_words, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
